key_pulse_conditioner: RTL
==========================

Name: key_pulse_conditioner

Overview:
- Sits directly downstream of the two-stage D flip-flop synchronizer on each player KEY input.
- Debounces the synchronized key level and produces a clean held level, a one-cycle press pulse and a one-cycle release pulse.
- The game control FSM and the ship-position logic consume these outputs.
- One instance per key.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive sampled cycles a new level must hold before it is accepted (5 ms at 50 MHz); legal range 1 to 2^CNT_W-1.
- CNT_W, 20, width of the debounce/repeat counter.
- REPEAT_DELAY, 15000000, cycles of continuous hold before the first auto-repeat pulse (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (AUTOREPEAT_EN only).

Ports:
- CLK  input  1  system clock (CLOCK_50 domain).
- RST_N  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; same effect as reset, applied at the clock edge.
- key_in  input  1  synchronized key level, 1 = pressed.
- held  output  1  debounced key level.
- press_pulse  output  1  single-cycle pulse on an accepted press.
- release_pulse  output  1  single-cycle pulse on an accepted release.

Behaviour:
- All outputs are registered. RST_N low asynchronously forces:
  - state = IDLE, cnt = 0
  - held = 0, press_pulse = 0, release_pulse = 0
- clr high at an edge has the identical effect. clr has priority over all transitions.
- Reset deassertion mid-press: the block restarts from IDLE. A key already down must re-qualify for DEBOUNCE_CYCLES before press_pulse fires.
- States and transitions:
  - IDLE:
    - key_in=0: stay; cnt=0.
    - key_in=1 and DEBOUNCE_CYCLES=1: go to HELD.
    - key_in=1 otherwise: go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - key_in=0: back to IDLE with cnt=0. Glitch rejected; no pulse.
    - key_in=1 and cnt=DEBOUNCE_CYCLES-1: go to HELD.
    - key_in=1 otherwise: cnt+1.
  - HELD:
    - key_in=1: stay.
    - key_in=0 and DEBOUNCE_CYCLES=1: go to IDLE.
    - key_in=0 otherwise: go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT:
    - key_in=1: back to HELD with cnt=0; no pulse.
    - key_in=0 and cnt=DEBOUNCE_CYCLES-1: go to IDLE.
    - key_in=0 otherwise: cnt+1.
- Latency: key_in must be sampled at the new level on DEBOUNCE_CYCLES consecutive edges.
  - On the DEBOUNCE_CYCLES-th such edge, held takes the new value.
  - On that same edge, press_pulse (rising) or release_pulse (falling) goes high, for exactly one cycle.
- press_pulse and release_pulse are never high in the same cycle. Each is high for at most one cycle per accepted transition.
- held equals 1 exactly in HELD and RELEASE_WAIT.
- cnt never wraps, because DEBOUNCE_CYCLES < 2^CNT_W. cnt is 0 in IDLE and HELD when no repeat is active.

Optional Feature:
- Macro: KEY_PULSE_AUTOREPEAT_EN.
- Defined:
  - While in HELD, a separate repeat counter (width CNT_W+4) runs from the cycle held rises.
  - The first extra press_pulse fires after REPEAT_DELAY cycles of continuous HELD, then every REPEAT_PERIOD cycles.
  - Entering RELEASE_WAIT, clr or reset clears the repeat counter.
  - Returning from RELEASE_WAIT to HELD resumes counting from 0.
  - Repeat pulses are exactly one cycle wide.
- Undefined: no repeat logic is synthesized; press_pulse fires once per accepted press only.

Test Plan:
- Run with DEBOUNCE_CYCLES=4 unless noted.
- Clean press: RST_N low 3 cycles, then release; key_in=1 for 10 cycles. Expect press_pulse high exactly on the 4th sampling edge, for 1 cycle; held=1 from the same edge.
- Glitch rejection: key_in=1 for 3 cycles then 0. Expect held, press_pulse and release_pulse to stay 0 throughout.
- Clean release: from HELD, key_in=0 for 6 cycles. Expect release_pulse high 1 cycle on the 4th edge; held=0 from the same edge. A 2-cycle low glitch from HELD produces no release_pulse and held stays 1.
- Async reset mid-operation: in PRESS_WAIT with cnt=2, pull RST_N low between edges. Expect all outputs 0 immediately. Release RST_N with key_in=1: press_pulse fires after 4 further sampling edges. A clr pulse while in HELD gives held=0 at the next edge with no release_pulse.
- DEBOUNCE_CYCLES=1: key_in pattern 0,1,1,0. Expect press_pulse on the first high edge and release_pulse on the first low edge; held tracks key_in delayed by 1 cycle.
- KEY_PULSE_AUTOREPEAT_EN with REPEAT_DELAY=20, REPEAT_PERIOD=8: hold key 60 cycles. Expect press_pulses at accept, accept+20, +28, +36, +44, +52, and none after release.

Source files
------------

// File: rtl/key_pulse_conditioner.sv
// Debouncer for one synchronized key: clean held level plus press/release pulses.
// Optional auto-repeat of press_pulse while held: define KEY_PULSE_AUTOREPEAT_EN.
module key_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 20
`ifdef KEY_PULSE_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 15000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic key_in,
    output logic held,
    output logic press_pulse,
    output logic release_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rep_hit;

`ifdef KEY_PULSE_AUTOREPEAT_EN
    localparam int unsigned RW = CNT_W + 4;
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_ONE   = RW'(1);

    logic [RW-1:0] rep_cnt;
    logic          rep_run;

    // First repeat waits the long delay, later ones the shorter period
    assign rep_hit = rep_run ? (rep_cnt == REP_NEXT) : (rep_cnt == REP_FIRST);

    // Repeat timer runs only while the key stays down in HELD
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rep_cnt <= '0;
            rep_run <= 1'b0;
        end else if (clr || state != HELD || !key_in) begin
            rep_cnt <= '0;
            rep_run <= 1'b0;
        end else if (rep_hit) begin
            rep_cnt <= '0;
            rep_run <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + REP_ONE;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    // Debounce FSM with registered level and edge pulses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            cnt           <= '0;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else if (clr) begin
            state         <= IDLE;
            cnt           <= '0;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!key_in) begin
                        cnt <= '0;
                    end else if (ONE_SHOT) begin
                        state       <= HELD;
                        cnt         <= '0;
                        held        <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_in) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= HELD;
                        cnt         <= '0;
                        held        <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (key_in) begin
                        press_pulse <= rep_hit;
                    end else if (ONE_SHOT) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_in) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule
